// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed driver for a 4-digit common-anode 7-segment
//               display. A prescaler produces one tick every TICK_DIV clocks.
//               Each tick advances the digit being shown. The BCD digits and
//               decimal points are captured into shadow registers only at a
//               frame boundary, so one frame never mixes old and new values.
//               Optional build macro SEG_LZ_BLANK_EN turns off leading zeros
//               on digits 3..1. Digit 0 is always shown.
// Ports       : clk        - clock
//               rst        - asynchronous active-high reset
//               nums[15:0] - BCD digits, [15:12] leftmost .. [3:0] rightmost
//               dp_mask    - decimal-point request per digit (1 = lit)
//               enable     - 1 = scan, 0 = dark
//               an[3:0]    - active-low digit anodes
//               seg[6:0]   - active-low cathodes {g,f,e,d,c,b,a}
//               dp         - active-low decimal-point cathode
//               frame_done - one-cycle pulse after the digit3 slot ends
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
  parameter int CLK_HZ  = 100000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] nums,
  input  logic [3:0]  dp_mask,
  input  logic        enable,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int c_tick_div = CLK_HZ / SCAN_HZ;
  localparam int c_pw       = (c_tick_div > 2) ? $clog2(c_tick_div) : 1;
  localparam logic [c_pw-1:0] c_presc_max = c_pw'(c_tick_div - 1);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_scan = 1'b1;

  logic [c_pw-1:0] r_presc;
  logic [0:0]      r_state;
  logic [1:0]      r_idx;
  logic [15:0]     r_sh_nums;
  logic [3:0]      r_sh_dp;

  logic            w_tick;
  logic [0:0]      w_state_nx;
  logic [1:0]      w_idx_nx;
  logic [15:0]     w_sh_nums_nx;
  logic [3:0]      w_sh_dp_nx;
  logic [3:0]      w_digit;
  logic            w_blank;

  assign w_tick = (r_presc == c_presc_max);

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;   // invalid BCD shows a dash
    endcase
    return s;
  endfunction

  // Prescaler only runs while enabled so a re-enable always starts a fresh
  // full slot before digit0 appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (!enable || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Next-state view is computed here so the registered outputs can show the
  // new digit on the very edge that advances idx.
  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_sh_nums_nx = r_sh_nums;
    w_sh_dp_nx   = r_sh_dp;
    if (!enable) begin
      w_state_nx = c_idle;
      w_idx_nx   = 2'd0;
    end else if (w_tick) begin
      if (r_state == c_idle) begin
        w_state_nx   = c_scan;
        w_idx_nx     = 2'd0;
        w_sh_nums_nx = nums;
        w_sh_dp_nx   = dp_mask;
      end else begin
        w_idx_nx = r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          w_sh_nums_nx = nums;
          w_sh_dp_nx   = dp_mask;
        end
      end
    end
  end

  always_comb begin
    case (w_idx_nx)
      2'd0:    w_digit = w_sh_nums_nx[3:0];
      2'd1:    w_digit = w_sh_nums_nx[7:4];
      2'd2:    w_digit = w_sh_nums_nx[11:8];
      default: w_digit = w_sh_nums_nx[15:12];
    endcase
  end

`ifdef SEG_LZ_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    case (w_idx_nx)
      2'd3:    w_blank = (w_sh_nums_nx[15:12] == 4'd0);
      2'd2:    w_blank = (w_sh_nums_nx[15:8] == 8'd0);
      2'd1:    w_blank = (w_sh_nums_nx[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_idle;
      r_idx      <= 2'd0;
      r_sh_nums  <= 16'd0;
      r_sh_dp    <= 4'd0;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_sh_nums  <= w_sh_nums_nx;
      r_sh_dp    <= w_sh_dp_nx;
      frame_done <= enable && w_tick && (r_state == c_scan) && (r_idx == 2'd3);
      if (w_state_nx == c_scan) begin
        an  <= ~(4'b0001 << w_idx_nx);
        seg <= w_blank ? 7'b1111111 : f_decode(w_digit);
        dp  <= ~w_sh_dp_nx[w_idx_nx];
      end else begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
        dp  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Self-checking bench for seg_scan_driver with CLK_HZ=16,
//               SCAN_HZ=4 (one tick every 4 clocks). A vector table covers
//               frame scanning, mid-frame input changes and decoding. Short
//               hand-written sequences cover disable, disable on a tick and
//               asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] nums;
  logic [3:0]  dp_mask;
  logic        enable;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

`ifdef SEG_LZ_BLANK_EN
  localparam logic [6:0] c_lz = 7'b1111111;
`else
  localparam logic [6:0] c_lz = 7'b1000000;
`endif

  seg_scan_driver #(.CLK_HZ(16), .SCAN_HZ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .nums       (nums),
    .dp_mask    (dp_mask),
    .enable     (enable),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] nums;
    logic [3:0]  dpm;
    logic        en;
    int          cyc;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        fd;
  } vec_t;

  vec_t vecs[18];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] e_an,
                       input logic [6:0] e_seg, input logic e_dp, input logic e_fd);
    checks++;
    if (an !== e_an || seg !== e_seg || dp !== e_dp || frame_done !== e_fd) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b dp=%b fd=%b, expected an=%b seg=%b dp=%b fd=%b",
               name, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
    end
  endtask

  initial begin
    // nums, dpm, en, cycles, an, seg, dp, fd
    vecs[0]  = '{16'h1234, 4'b0000, 1'b1, 3, 4'b1111, 7'b1111111, 1'b1, 1'b0}; // still idle
    vecs[1]  = '{16'h1234, 4'b0000, 1'b1, 1, 4'b1110, 7'b0011001, 1'b1, 1'b0}; // d0=4
    vecs[2]  = '{16'h1234, 4'b0000, 1'b1, 4, 4'b1101, 7'b0110000, 1'b1, 1'b0}; // d1=3
    vecs[3]  = '{16'h1234, 4'b0000, 1'b1, 4, 4'b1011, 7'b0100100, 1'b1, 1'b0}; // d2=2
    vecs[4]  = '{16'h1234, 4'b0000, 1'b1, 4, 4'b0111, 7'b1111001, 1'b1, 1'b0}; // d3=1
    vecs[5]  = '{16'h1234, 4'b0000, 1'b1, 4, 4'b1110, 7'b0011001, 1'b1, 1'b1}; // wrap, pulse
    vecs[6]  = '{16'h1234, 4'b0000, 1'b1, 1, 4'b1110, 7'b0011001, 1'b1, 1'b0}; // pulse ends
    vecs[7]  = '{16'h1234, 4'b0000, 1'b1, 3, 4'b1101, 7'b0110000, 1'b1, 1'b0}; // idx1
    vecs[8]  = '{16'h5678, 4'b0000, 1'b1, 4, 4'b1011, 7'b0100100, 1'b1, 1'b0}; // old 2
    vecs[9]  = '{16'h5678, 4'b0000, 1'b1, 4, 4'b0111, 7'b1111001, 1'b1, 1'b0}; // old 1
    vecs[10] = '{16'h5678, 4'b0000, 1'b1, 4, 4'b1110, 7'b0000000, 1'b1, 1'b1}; // new 8
    vecs[11] = '{16'h5678, 4'b0000, 1'b1, 4, 4'b1101, 7'b1111000, 1'b1, 1'b0}; // 7
    vecs[12] = '{16'h5678, 4'b0000, 1'b1, 4, 4'b1011, 7'b0000010, 1'b1, 1'b0}; // 6
    vecs[13] = '{16'h5678, 4'b0000, 1'b1, 4, 4'b0111, 7'b0010010, 1'b1, 1'b0}; // 5
    vecs[14] = '{16'h00A9, 4'b0010, 1'b1, 4, 4'b1110, 7'b0010000, 1'b1, 1'b1}; // 9
    vecs[15] = '{16'h00A9, 4'b0010, 1'b1, 4, 4'b1101, 7'b0111111, 1'b0, 1'b0}; // dash + dp
    vecs[16] = '{16'h00A9, 4'b0010, 1'b1, 4, 4'b1011, c_lz,       1'b1, 1'b0}; // 0 / blank
    vecs[17] = '{16'h00A9, 4'b0010, 1'b1, 4, 4'b0111, c_lz,       1'b1, 1'b0}; // 0 / blank

    rst     = 1'b1;
    enable  = 1'b0;
    nums    = 16'h0000;
    dp_mask = 4'b0000;
    step(2);
    check("reset_dark", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      nums    = vecs[i].nums;
      dp_mask = vecs[i].dpm;
      enable  = vecs[i].en;
      step(vecs[i].cyc);
      check($sformatf("vec%0d", i), vecs[i].an, vecs[i].seg, vecs[i].dp, vecs[i].fd);
    end

    // Disable mid-frame (idx3, not a tick cycle): dark next cycle.
    enable = 1'b0;
    step(1);
    check("dis_mid_dark", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(8);
    check("dis_mid_stay", 4'b1111, 7'b1111111, 1'b1, 1'b0);

    // Re-enable with all zeros: restart at digit0, leading-zero handling.
    nums    = 16'h0000;
    dp_mask = 4'b0000;
    enable  = 1'b1;
    step(3);
    check("reen_wait", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(1);
    check("reen_d0", 4'b1110, 7'b1000000, 1'b1, 1'b0);
    step(4);
    check("zero_d1", 4'b1101, c_lz, 1'b1, 1'b0);
    step(4);
    check("zero_d2", 4'b1011, c_lz, 1'b1, 1'b0);
    step(4);
    check("zero_d3", 4'b0111, c_lz, 1'b1, 1'b0);

    // Disable on the tick that would end digit3: no pulse, dark.
    step(3);
    enable = 1'b0;
    step(1);
    check("dis_tick_dark", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(5);
    check("dis_tick_nofd", 4'b1111, 7'b1111111, 1'b1, 1'b0);

    // Asynchronous reset while showing digit2.
    nums    = 16'h1234;
    dp_mask = 4'b0100;
    enable  = 1'b1;
    step(4);
    check("pre_rst_d0", 4'b1110, 7'b0011001, 1'b1, 1'b0);
    step(8);
    check("pre_rst_d2", 4'b1011, 7'b0100100, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dark", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(1);
    rst = 1'b0;
    step(3);
    check("post_rst_wait", 4'b1111, 7'b1111111, 1'b1, 1'b0);
    step(1);
    check("post_rst_d0", 4'b1110, 7'b0011001, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
